ibex_multdiv_iter: RTL and testbench

Parametrised, self-contained iterative multiplier/divider for the Ibex M-extension. It replaces the shared-ALU slow multdiv with an internal adder and a configurable operand width and retire rate (1 or 2 quotient/product bits per cycle). It adds a request/response handshake with back-pressure and a kill input for flushes. It sits in the EX stage beside the ALU and is selected by the decoder for MUL*/DIV*/REM* instructions.

---
 rtl/ibex_multdiv_iter.sv | 221 ++++++++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiplier/divider for the M extension: shift-add multiply and
// restoring division retiring 1 or 2 bits per cycle, with result back-pressure and kill.
module ibex_multdiv_iter #(
  parameter int Width        = 32,
  parameter int BitsPerCycle = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             ready_o,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o,
  output logic [1:0]       dbg_state_o
);

  localparam int N    = Width / BitsPerCycle;
  localparam int CntW = $clog2(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COMP  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_MULL = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;

  generate
    if (BitsPerCycle != 1 && BitsPerCycle != 2) begin : g_bpc_check
      $error("ibex_multdiv_iter: BitsPerCycle must be 1 or 2");
    end
    if ((Width % 2) != 0 || Width < 8) begin : g_width_check
      $error("ibex_multdiv_iter: Width must be even and >= 8");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [1:0]         r_op;
  logic               r_sa;
  logic               r_sb;
  logic               r_dit;
  logic               r_b_zero;
  logic [CntW-1:0]    r_cnt;
  logic [2*Width-1:0] r_acc;
  logic [2*Width-1:0] r_mcand;
  logic [2*Width-1:0] r_mcand3;
  logic [Width-1:0]   r_mplier;
  logic [Width-1:0]   r_result;

  logic               w_sa;
  logic               w_sb;
  logic [Width-1:0]   w_abs_a;
  logic [Width-1:0]   w_abs_b;
  logic [Width+1:0]   w_abs_a3;
  logic [Width+1:0]   w_abs_b3;
  logic               w_dz_short;
  logic [2*Width-1:0] w_addend;
  logic [2*Width-1:0] w_mul_acc;
  logic [Width-1:0]   w_mplier_nxt;
  logic               w_early;
  logic [Width+2:0]   w_sh;
  logic [Width+2:0]   w_b1;
  logic [Width+2:0]   w_b2;
  logic [Width+2:0]   w_b3;
  logic [Width+2:0]   w_d1;
  logic [Width+2:0]   w_d2;
  logic [Width+2:0]   w_d3;
  logic [1:0]         w_qbits;
  logic [Width-1:0]   w_rem_nxt;
  logic [2*Width-1:0] w_div_acc;
  logic [2*Width-1:0] w_prod;
  logic [Width-1:0]   w_quo;
  logic [Width-1:0]   w_rem;
  logic [Width-1:0]   w_fix_res;

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign result_o    = valid_o ? r_result : '0;
  assign dbg_state_o = r_state;

  assign w_sa       = op_a_i[Width-1] & signed_mode_i[0];
  assign w_sb       = op_b_i[Width-1] & signed_mode_i[1];
  assign w_abs_a    = w_sa ? -op_a_i : op_a_i;
  assign w_abs_b    = w_sb ? -op_b_i : op_b_i;
  assign w_abs_a3   = {2'b00, w_abs_a} + {1'b0, w_abs_a, 1'b0};
  assign w_abs_b3   = {2'b00, w_abs_b} + {1'b0, w_abs_b, 1'b0};
  assign w_dz_short = operator_i[1] & ~data_ind_timing_i & (op_b_i == '0);

  // Multiplicand shifts left while multiplier shifts right, so stopping early leaves a finished product.
  always_comb begin
    w_addend = '0;
    if (BitsPerCycle == 1) begin
      if (r_mplier[0]) w_addend = r_mcand;
    end else begin
      case (r_mplier[1:0])
        2'd1:    w_addend = r_mcand;
        2'd2:    w_addend = r_mcand << 1;
        2'd3:    w_addend = r_mcand3;
        default: w_addend = '0;
      endcase
    end
  end

  assign w_mul_acc    = r_acc + w_addend;
  assign w_mplier_nxt = r_mplier >> BitsPerCycle;
  assign w_early      = (r_op == OP_MULL) & ~r_dit & (w_mplier_nxt == '0);

  // Divide keeps {remainder, dividend/quotient} in r_acc; a set top bit on a difference means borrow.
  always_comb begin
    w_b1 = {3'b000, r_mcand[Width-1:0]};
    w_b2 = {2'b00, r_mcand[Width-1:0], 1'b0};
    w_b3 = {1'b0, r_mcand3[Width+1:0]};
    if (BitsPerCycle == 1) w_sh = {2'b00, r_acc[2*Width-1:Width], r_acc[Width-1]};
    else                   w_sh = {1'b0, r_acc[2*Width-1:Width], r_acc[Width-1:Width-2]};
    w_d1      = w_sh - w_b1;
    w_d2      = w_sh - w_b2;
    w_d3      = w_sh - w_b3;
    w_qbits   = 2'b00;
    w_rem_nxt = w_sh[Width-1:0];
    if (BitsPerCycle == 2 && !w_d3[Width+2]) begin
      w_qbits   = 2'b11;
      w_rem_nxt = w_d3[Width-1:0];
    end else if (BitsPerCycle == 2 && !w_d2[Width+2]) begin
      w_qbits   = 2'b10;
      w_rem_nxt = w_d2[Width-1:0];
    end else if (!w_d1[Width+2]) begin
      w_qbits   = 2'b01;
      w_rem_nxt = w_d1[Width-1:0];
    end
    if (BitsPerCycle == 1) w_div_acc = {w_rem_nxt, r_acc[Width-2:0], w_qbits[0]};
    else                   w_div_acc = {w_rem_nxt, r_acc[Width-3:0], w_qbits};
  end

  always_comb begin
    w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_quo  = r_acc[Width-1:0];
    w_rem  = r_acc[2*Width-1:Width];
    case (r_op)
      OP_MULL: w_fix_res = w_prod[Width-1:0];
      OP_MULH: w_fix_res = w_prod[2*Width-1:Width];
      OP_DIV:  w_fix_res = ((r_sa ^ r_sb) & ~r_b_zero) ? -w_quo : w_quo;
      default: w_fix_res = r_sa ? -w_rem : w_rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dit    <= 1'b0;
      r_b_zero <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mcand3 <= '0;
      r_mplier <= '0;
      r_result <= '0;
    end else if (kill_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_op     <= operator_i;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_dit    <= data_ind_timing_i;
            r_b_zero <= (op_b_i == '0);
            r_cnt    <= CntW'(N - 1);
            if (operator_i[1]) begin
              r_acc    <= {{Width{1'b0}}, w_abs_a};
              r_mcand  <= {{Width{1'b0}}, w_abs_b};
              r_mcand3 <= {{(Width-2){1'b0}}, w_abs_b3};
              r_mplier <= '0;
            end else begin
              r_acc    <= '0;
              r_mcand  <= {{Width{1'b0}}, w_abs_a};
              r_mcand3 <= {{(Width-2){1'b0}}, w_abs_a3};
              r_mplier <= w_abs_b;
            end
            if (w_dz_short) begin
              r_result <= (operator_i == OP_DIV) ? '1 : op_a_i;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_COMP;
            end
          end
        end
        S_COMP: begin
          if (r_op[1]) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc    <= w_mul_acc;
            r_mcand  <= r_mcand << BitsPerCycle;
            r_mcand3 <= r_mcand3 << BitsPerCycle;
            r_mplier <= w_mplier_nxt;
          end
          if (r_cnt == '0 || w_early) r_state <= S_FIXUP;
          else                        r_cnt   <= r_cnt - CntW'(1);
        end
        S_FIXUP: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: begin
          if (ready_i) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed and random checks of ibex_multdiv_iter at 1 and 2 bits per cycle against
// an arithmetic reference model, including latency, back-pressure, kill and reset.
module tb_ibex_multdiv_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   operator;
  logic [1:0]   signed_mode;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         dit;

  logic         req1, kill1, rdy1, ready1, valid1;
  logic [W-1:0] result1;
  logic [1:0]   state1;
  logic         req2, kill2, rdy2, ready2, valid2;
  logic [W-1:0] result2;
  logic [1:0]   state2;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ibex_multdiv_iter #(.Width(W), .BitsPerCycle(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .ready_o(ready1),
    .operator_i(operator), .signed_mode_i(signed_mode), .op_a_i(op_a), .op_b_i(op_b),
    .data_ind_timing_i(dit), .kill_i(kill1), .valid_o(valid1), .ready_i(rdy1),
    .result_o(result1), .dbg_state_o(state1)
  );

  ibex_multdiv_iter #(.Width(W), .BitsPerCycle(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .ready_o(ready2),
    .operator_i(operator), .signed_mode_i(signed_mode), .op_a_i(op_a), .op_b_i(op_b),
    .data_ind_timing_i(dit), .kill_i(kill2), .valid_o(valid2), .ready_i(rdy2),
    .result_o(result2), .dbg_state_o(state2)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] ea, eb, p, qv, rv;
    longint      qa, qb;
    ea = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
    if (!op[1]) begin
      p = ea * eb;
      return (op == 2'd0) ? p[31:0] : p[63:32];
    end
    if (b == '0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
    qa = $signed(ea);
    qb = $signed(eb);
    qv = qa / qb;
    rv = qa % qb;
    return (op == 2'd2) ? qv[31:0] : rv[31:0];
  endfunction

  function automatic int exp_lat(input int bpc, input logic [1:0] op, input logic [1:0] sm,
                                 input logic [W-1:0] b, input logic d);
    logic [W-1:0] mag;
    int bits, k;
    if (op[1] && !d && b == '0) return 1;
    if (op == 2'd0 && !d) begin
      mag = (b[31] & sm[1]) ? -b : b;
      bits = 0;
      for (int i = 0; i < W; i++) if (mag[i]) bits = i + 1;
      k = (bits + bpc - 1) / bpc;
      if (k < 1) k = 1;
      return k + 2;
    end
    return W / bpc + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic do_op(input int sel, input logic [1:0] op, input logic [1:0] sm,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic d,
                       input int hold, input string tag);
    int           lat, cyc;
    logic [W-1:0] exp_v;
    lat = exp_lat(sel, op, sm, b, d);
    operator = op; signed_mode = sm; op_a = a; op_b = b; dit = d;
    exp_q.push_back(ref_op(op, sm, a, b));
    check({tag, ":ready_idle"}, 32'(sel == 1 ? ready1 : ready2), 32'd1);
    if (sel == 1) req1 = 1'b1; else req2 = 1'b1;
    tick();
    req1 = 1'b0; req2 = 1'b0;
    op_a = $urandom; op_b = $urandom;
    operator = 2'($urandom_range(0, 3)); signed_mode = 2'($urandom_range(0, 3));
    dit = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!(sel == 1 ? valid1 : valid2) && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, ":latency"}, 32'(cyc), 32'(lat));
    exp_v = exp_q.pop_front();
    check({tag, ":result"}, sel == 1 ? result1 : result2, exp_v);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, ":hold_valid"}, 32'(sel == 1 ? valid1 : valid2), 32'd1);
      check({tag, ":hold_result"}, sel == 1 ? result1 : result2, exp_v);
      check({tag, ":hold_ready"}, 32'(sel == 1 ? ready1 : ready2), 32'd0);
    end
    if (sel == 1) rdy1 = 1'b1; else rdy2 = 1'b1;
    tick();
    rdy1 = 1'b0; rdy2 = 1'b0;
    check({tag, ":valid_drop"}, 32'(sel == 1 ? valid1 : valid2), 32'd0);
    check({tag, ":result_zero"}, sel == 1 ? result1 : result2, 32'd0);
    check({tag, ":ready_back"}, 32'(sel == 1 ? ready1 : ready2), 32'd1);
  endtask

  initial begin
    req1 = 0; kill1 = 0; rdy1 = 0; req2 = 0; kill2 = 0; rdy2 = 0;
    operator = 0; signed_mode = 0; op_a = 0; op_b = 0; dit = 0;
    #1;
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_result1", result1, 32'd0);
    check("rst_state1", 32'(state1), 32'd0);
    check("rst_ready2", 32'(ready2), 32'd1);
    check("rst_valid2", 32'(valid2), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Width 32, one bit per cycle
    do_op(1, 2'd0, 2'b11, 32'd7, -32'sd3, 1'b0, 0, "mull_7x-3_eo");
    do_op(1, 2'd0, 2'b11, 32'd7, 32'hFFFF_FFFF, 1'b0, 0, "mull_7x-1_eo");
    do_op(1, 2'd0, 2'b00, 32'h1234, 32'd0, 1'b0, 0, "mull_x0_eo");
    do_op(1, 2'd0, 2'b11, 32'd7, -32'sd3, 1'b1, 0, "mull_7x-3_dit");
    do_op(1, 2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, "mulh_ss");
    do_op(1, 2'd1, 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, "mulh_uu");
    do_op(1, 2'd1, 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, "mulh_su");
    do_op(1, 2'd2, 2'b11, -32'sd7, 32'd2, 1'b1, 0, "div_-7_2");
    do_op(1, 2'd3, 2'b11, -32'sd7, 32'd2, 1'b1, 0, "rem_-7_2");
    do_op(1, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_ovf");
    do_op(1, 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "rem_ovf");
    do_op(1, 2'd2, 2'b11, 32'h1234, 32'd0, 1'b0, 0, "div0_short");
    do_op(1, 2'd3, 2'b11, 32'h1234, 32'd0, 1'b0, 0, "rem0_short");
    do_op(1, 2'd2, 2'b11, 32'h1234, 32'd0, 1'b1, 0, "div0_full");
    do_op(1, 2'd3, 2'b11, 32'h1234, 32'd0, 1'b1, 0, "rem0_full");
    do_op(1, 2'd3, 2'b11, -32'sd9, 32'd0, 1'b1, 0, "rem0_neg_full");
    do_op(1, 2'd0, 2'b11, 32'd5, 32'd6, 1'b1, 5, "hold5");

    // kill partway through the COMP phase
    operator = 2'd2; signed_mode = 2'b11; op_a = 32'd1000; op_b = 32'd7; dit = 1'b1;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("kill_in_comp", 32'(state1), 32'd1);
    kill1 = 1'b1;
    tick();
    kill1 = 1'b0;
    check("kill_ready", 32'(ready1), 32'd1);
    check("kill_valid", 32'(valid1), 32'd0);
    repeat (3) tick();
    check("kill_stays_idle", 32'(state1), 32'd0);

    // request coinciding with kill in IDLE is dropped
    operator = 2'd2; signed_mode = 2'b00; op_a = 32'h55; op_b = 32'd0; dit = 1'b0;
    req1 = 1'b1; kill1 = 1'b1;
    tick();
    req1 = 1'b0; kill1 = 1'b0;
    check("reqkill_state", 32'(state1), 32'd0);
    check("reqkill_valid", 32'(valid1), 32'd0);
    check("reqkill_ready", 32'(ready1), 32'd1);

    do_op(1, 2'd2, 2'b11, 32'd100, -32'sd7, 1'b1, 0, "after_kill_div");

    // asynchronous reset in the middle of an operation
    operator = 2'd1; signed_mode = 2'b11; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; dit = 1'b1;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready1), 32'd1);
    check("midrst_valid", 32'(valid1), 32'd0);
    check("midrst_result", result1, 32'd0);
    check("midrst_state", 32'(state1), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < 60; i++)
      do_op(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(), pick(),
            1'($urandom_range(0, 1)), 0, "rnd_bpc1");

    // two bits per cycle
    do_op(2, 2'd1, 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, "bpc2_mulh_su");
    do_op(2, 2'd0, 2'b11, 32'd7, -32'sd3, 1'b0, 0, "bpc2_mull_eo");
    do_op(2, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "bpc2_div_ovf");
    do_op(2, 2'd3, 2'b10, 32'hFFFF_FFF9, 32'h8000_0000, 1'b1, 2, "bpc2_rem_mixed");
    do_op(2, 2'd2, 2'b11, 32'h1234, 32'd0, 1'b1, 0, "bpc2_div0_full");
    do_op(2, 2'd2, 2'b11, 32'h1234, 32'd0, 1'b0, 0, "bpc2_div0_short");
    for (int i = 0; i < 300; i++)
      do_op(2, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(), pick(),
            1'b1, 0, "rnd_bpc2_dit");
    for (int i = 0; i < 60; i++)
      do_op(2, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(), pick(),
            1'b0, 0, "rnd_bpc2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
